tl_master_port: RTL and testbench
=================================

Name: tl_master_port

Overview:
- TileLink-UL/UH initiator that turns single core-side memory requests (load, store, AMO) into one A-channel beat.
- Collects the matching D-channel response and returns size-extended read data to the requester.
- Sits between the core's LSU/fetch logic and any `tilelink.slave` responder (RAM, MMIO).
- Strictly one outstanding transaction, with a watchdog timeout.

Parameters:
- SRC_ID, 0: value driven on a_source; responses with any other d_source are ignored.
- TIMEOUT, 1024: cycles to wait in RESP before an error response is forced; 0 disables the watchdog.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_op  input  3  0=LOAD, 1=STORE, 2=ARITH, 3=LOGIC; others reserved, treated as LOAD
- req_param  input  3  atomic param (`TL_PARAM_ADD/MIN/MAX/MINU/MAXU/SWAP/XOR/OR/AND`), driven onto a_param
- req_size  input  2  log2 bytes (0..3)
- req_signed  input  1  sign-extend the returned data (otherwise zero-extend)
- req_addr  input  64  byte address
- req_wdata  input  64  LSB-aligned write/operand data
- rsp_valid  output  1  one-cycle response strobe
- rsp_data  output  64  extended read data (0 for STORE/error)
- rsp_denied  output  1  copy of d_denied from the accepted beat
- rsp_err  output  1  timeout occurred
- bus  tilelink.master  —  A-channel outputs; D-channel inputs; d_ready output

Behaviour:
- Reset:
  - Asynchronous, active-low; clk and rst_n are the only clock and reset.
  - state=IDLE; a_valid=0, d_ready=0, rsp_valid=0, rsp_err=0, rsp_denied=0, rsp_data=0.
  - All A-channel payload=0, timeout counter=0.
  - Reset mid-transaction abandons it; no rsp_valid is produced.
- State machine: IDLE -> REQ -> RESP -> IDLE.
  - req_ready=1 only in IDLE (combinational from state).
- IDLE:
  - On req_valid, register the A payload; next cycle a_valid=1 (state REQ).
  - Opcode mapping: LOAD→`TL_GET`, STORE→`TL_PUT_F` if size==3 else `TL_PUT_P`, ARITH→`TL_ARITH_DATA`, LOGIC→`TL_LOGIC_DATA`.
  - a_size={1'b0,req_size}; a_address=req_addr.
  - a_data=req_wdata, unshifted (the responder shifts lanes by address offset).
  - a_mask is LSB-aligned, unshifted: size0=8'h01, 1=8'h03, 2=8'h0F, 3=8'hFF.
  - a_param=req_param for atomics, else 0; a_corrupt=0; a_source=SRC_ID.
- REQ:
  - Payload and a_valid held stable until a_valid&&a_ready is sampled at a clk edge; a_valid must not drop early.
  - On that edge: a_valid=0, d_ready=1, counter cleared, state RESP.
  - d_ready stays 0 in IDLE/REQ; a D beat arriving then is not consumed.
- RESP:
  - Beat accepted on d_valid&&d_ready&&(d_source==SRC_ID); next cycle rsp_valid=1 for exactly one cycle, d_ready=0, state IDLE.
  - A beat with mismatching d_source is dropped and waiting continues.
  - Same-cycle d_valid and timeout expiry: the beat wins, rsp_err=0.
- Counter (TIMEOUT≠0):
  - Increments each RESP cycle without acceptance.
  - When counter==TIMEOUT-1 with no beat: rsp_valid=1, rsp_err=1, rsp_data=0, state IDLE.
- Data extension (from d_data[63:0], lane 0):
  - size0 bits[7:0], size1 bits[15:0], size2 bits[31:0], size3 full.
  - Upper bits = req_signed ? MSB of field : 0.
  - Applies to LOAD/ARITH/LOGIC; STORE returns 0 regardless of d_data.
  - Size and signedness come from values registered at request time, not d_size.
- Back-to-back:
  - Next request is accepted in the cycle rsp_valid is high (state already IDLE); a_valid then rises one cycle later.
  - Minimum 3 cycles request→response with zero-wait responder.

Test Plan:
- LOAD size=2 signed, addr 0x1004, responder d_data=0x0000_0000_8000_0001 → a_opcode=`TL_GET`, a_mask=0x0F, a_size=2; rsp_data=0xFFFF_FFFF_8000_0001, rsp_err=0.
- STORE size=0, addr 0x2003, wdata 0xAB; a_ready held low 4 cycles → a_valid/payload stable all 4 cycles, opcode `TL_PUT_P`, mask 0x01; rsp_data=0.
- ARITH ADD size=3, wdata 5, old value 10 → a_param=`TL_PARAM_ADD`, opcode `TL_ARITH_DATA`, mask 0xFF; rsp_data=10.
- RESP phase: beat with d_source=SRC_ID+1, then the correct beat 2 cycles later → first ignored; single rsp_valid carrying the second beat's data.
- TIMEOUT=8, responder never answers → rsp_valid with rsp_err=1, rsp_data=0 exactly 8 cycles after A handshake; next request accepted.
- rst_n low while in REQ → a_valid=0 asynchronously, no rsp_valid after release; following LOAD size=1 unsigned of 0xFFFF returns 0x0000_0000_0000_FFFF.

Source files
------------

// File: rtl/tl_master_port_if.sv
// TileLink-UL/UH channel bundle (A and D channels) shared by initiators and responders.
interface tilelink;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [2:0]  a_size;
  logic [7:0]  a_source;
  logic [63:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        a_corrupt;

  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [2:0]  d_size;
  logic [7:0]  d_source;
  logic        d_denied;
  logic [63:0] d_data;
  logic        d_corrupt;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt,
    input  d_ready
  );
endinterface

// File: rtl/tl_master_port.sv
// Single-outstanding TileLink initiator: one core request becomes one A beat, the
// matching D beat (or a watchdog timeout) becomes a one-cycle response strobe.
module tl_master_port #(
  parameter logic [7:0]  SRC_ID  = 8'd0,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [2:0]  req_param,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_data,
  output logic        rsp_denied,
  output logic        rsp_err,
  tilelink.master     bus
);

  localparam logic [2:0] TL_PUT_F      = 3'd0;
  localparam logic [2:0] TL_PUT_P      = 3'd1;
  localparam logic [2:0] TL_ARITH_DATA = 3'd2;
  localparam logic [2:0] TL_LOGIC_DATA = 3'd3;
  localparam logic [2:0] TL_GET        = 3'd4;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e      state_q, state_d;
  logic [2:0]  a_opcode_q, a_opcode_d;
  logic [2:0]  a_param_q, a_param_d;
  logic [2:0]  a_size_q, a_size_d;
  logic [7:0]  a_source_q, a_source_d;
  logic [63:0] a_address_q, a_address_d;
  logic [7:0]  a_mask_q, a_mask_d;
  logic [63:0] a_data_q, a_data_d;
  logic        store_q, store_d;
  logic        signed_q, signed_d;
  logic [31:0] cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_denied_q, rsp_denied_d;
  logic [63:0] rsp_data_q, rsp_data_d;

  logic        accept;
  logic        beat_ok;
  logic        timeout_hit;
  logic [63:0] ext_data;

  assign accept      = (state_q == IDLE) && req_valid;
  assign beat_ok     = (state_q == RESP) && bus.d_valid && (bus.d_source == SRC_ID);
  // A beat arriving in the expiry cycle takes priority over the timeout.
  assign timeout_hit = (TIMEOUT != 0) && (state_q == RESP) && !beat_ok &&
                       (cnt_q == 32'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = REQ;
      REQ:     if (bus.a_ready) state_d = RESP;
      RESP:    if (beat_ok || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state_q == IDLE);
    bus.a_valid = (state_q == REQ);
    bus.d_ready = (state_q == RESP);
  end

  // Extension uses the size/signedness captured at request time, not d_size.
  always_comb begin
    ext_data = '0;
    unique case (a_size_q[1:0])
      2'd0: ext_data = {{56{signed_q & bus.d_data[7]}},  bus.d_data[7:0]};
      2'd1: ext_data = {{48{signed_q & bus.d_data[15]}}, bus.d_data[15:0]};
      2'd2: ext_data = {{32{signed_q & bus.d_data[31]}}, bus.d_data[31:0]};
      default: ext_data = bus.d_data;
    endcase
  end

  always_comb begin
    a_opcode_d   = a_opcode_q;
    a_param_d    = a_param_q;
    a_size_d     = a_size_q;
    a_source_d   = a_source_q;
    a_address_d  = a_address_q;
    a_mask_d     = a_mask_q;
    a_data_d     = a_data_q;
    store_d      = store_q;
    signed_d     = signed_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = rsp_err_q;
    rsp_denied_d = rsp_denied_q;
    rsp_data_d   = rsp_data_q;

    if (accept) begin
      unique case (req_op)
        3'd1:    a_opcode_d = (req_size == 2'd3) ? TL_PUT_F : TL_PUT_P;
        3'd2:    a_opcode_d = TL_ARITH_DATA;
        3'd3:    a_opcode_d = TL_LOGIC_DATA;
        default: a_opcode_d = TL_GET;
      endcase
      a_param_d   = (req_op == 3'd2 || req_op == 3'd3) ? req_param : '0;
      a_size_d    = {1'b0, req_size};
      a_source_d  = SRC_ID;
      a_address_d = req_addr;
      a_data_d    = req_wdata;
      unique case (req_size)
        2'd0:    a_mask_d = 8'h01;
        2'd1:    a_mask_d = 8'h03;
        2'd2:    a_mask_d = 8'h0F;
        default: a_mask_d = 8'hFF;
      endcase
      store_d  = (req_op == 3'd1);
      signed_d = req_signed;
    end

    if (state_q == REQ) cnt_d = '0;
    else if (state_q == RESP && !beat_ok) cnt_d = cnt_q + 32'd1;

    if (beat_ok) begin
      rsp_valid_d  = 1'b1;
      rsp_err_d    = 1'b0;
      rsp_denied_d = bus.d_denied;
      rsp_data_d   = store_q ? '0 : ext_data;
    end else if (timeout_hit) begin
      rsp_valid_d  = 1'b1;
      rsp_err_d    = 1'b1;
      rsp_denied_d = 1'b0;
      rsp_data_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_opcode_q   <= '0;
      a_param_q    <= '0;
      a_size_q     <= '0;
      a_source_q   <= '0;
      a_address_q  <= '0;
      a_mask_q     <= '0;
      a_data_q     <= '0;
      store_q      <= 1'b0;
      signed_q     <= 1'b0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_denied_q <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      a_opcode_q   <= a_opcode_d;
      a_param_q    <= a_param_d;
      a_size_q     <= a_size_d;
      a_source_q   <= a_source_d;
      a_address_q  <= a_address_d;
      a_mask_q     <= a_mask_d;
      a_data_q     <= a_data_d;
      store_q      <= store_d;
      signed_q     <= signed_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_denied_q <= rsp_denied_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign bus.a_opcode  = a_opcode_q;
  assign bus.a_param   = a_param_q;
  assign bus.a_size    = a_size_q;
  assign bus.a_source  = a_source_q;
  assign bus.a_address = a_address_q;
  assign bus.a_mask    = a_mask_q;
  assign bus.a_data    = a_data_q;
  assign bus.a_corrupt = 1'b0;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_denied = rsp_denied_q;
  assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_tl_master_port.sv
// Bench for tl_master_port: directed scenarios plus randomized traffic against a
// behavioural model of opcode/mask mapping and response data extension.
module tb_tl_master_port;
  localparam logic [7:0]  SRC = 8'd3;
  localparam int unsigned TO  = 8;
  localparam logic [2:0]  TL_PARAM_ADD = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [2:0]  req_param = '0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_denied;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  tilelink tl ();

  tl_master_port #(.SRC_ID(SRC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_param(req_param),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_denied(rsp_denied), .rsp_err(rsp_err),
    .bus(tl)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] ref_opcode(input logic [2:0] op, input logic [1:0] size);
    if (op == 3'd1) return (size == 2'd3) ? 3'd0 : 3'd1;
    if (op == 3'd2) return 3'd2;
    if (op == 3'd3) return 3'd3;
    return 3'd4;
  endfunction

  function automatic logic [63:0] ref_ext(input logic [63:0] d, input logic [1:0] size, input logic sgn);
    int unsigned bits;
    logic [63:0] m, f;
    bits = 8 << size;
    m = (bits == 64) ? '1 : ((64'd1 << bits) - 64'd1);
    f = d & m;
    if (sgn && f[bits-1]) f = f | ~m;
    return f;
  endfunction

  function automatic logic [153:0] ref_payload(input logic [2:0] op, input logic [2:0] param,
      input logic [1:0] size, input logic [63:0] addr, input logic [63:0] wdata);
    logic [7:0] mask;
    logic [2:0] p;
    mask = 8'((16'd1 << (1 << size)) - 16'd1);
    p = (op == 3'd2 || op == 3'd3) ? param : 3'd0;
    return {ref_opcode(op, size), p, {1'b0, size}, SRC, addr, mask, wdata, 1'b0};
  endfunction

  function automatic logic [153:0] dut_payload();
    return {tl.a_opcode, tl.a_param, tl.a_size, tl.a_source, tl.a_address, tl.a_mask,
            tl.a_data, tl.a_corrupt};
  endfunction

  // Leaves the bench in the cycle where rsp_valid is high, so a following call is back-to-back.
  task automatic do_txn(input string tag, input logic [2:0] op, input logic [2:0] param,
      input logic [1:0] size, input logic sgn, input logic [63:0] addr, input logic [63:0] wdata,
      input logic [63:0] ddata, input int a_wait, input int d_wait, input int bad_at,
      input logic denied);
    logic [153:0] exp_pl;
    logic [63:0]  exp_data;
    exp_pl   = ref_payload(op, param, size, addr, wdata);
    exp_data = (op == 3'd1) ? 64'd0 : ref_ext(ddata, size, sgn);

    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready got %b exp 1", tag, req_ready);
    end
    req_valid = 1'b1; req_op = op; req_param = param; req_size = size;
    req_signed = sgn; req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0; req_op = 3'($urandom); req_size = 2'($urandom); req_signed = ~sgn;
    req_wdata = {$urandom, $urandom};
    checks++;
    if ({tl.a_valid, rsp_valid, req_ready} !== 3'b100) begin
      errors++; $display("FAIL %s a_valid/rsp_valid/req_ready got %b exp 100", tag,
                         {tl.a_valid, rsp_valid, req_ready});
    end
    for (int i = 0; i < a_wait; i++) begin
      tl.d_valid = 1'b1; tl.d_source = SRC; tl.d_data = ~ddata;
      checks++;
      if ({tl.a_valid, tl.d_ready, dut_payload()} !== {2'b10, exp_pl}) begin
        errors++; $display("FAIL %s stall%0d payload got %h exp %h", tag, i,
                           {tl.a_valid, tl.d_ready, dut_payload()}, {2'b10, exp_pl});
      end
      tick();
    end
    tl.d_valid = 1'b0;
    tl.a_ready = 1'b1;
    checks++;
    if ({tl.a_valid, dut_payload()} !== {1'b1, exp_pl}) begin
      errors++; $display("FAIL %s payload got %h exp %h", tag, {tl.a_valid, dut_payload()},
                         {1'b1, exp_pl});
    end
    tick();
    tl.a_ready = 1'b0;
    checks++;
    if ({tl.a_valid, tl.d_ready} !== 2'b01) begin
      errors++; $display("FAIL %s after A handshake a_valid/d_ready got %b exp 01", tag,
                         {tl.a_valid, tl.d_ready});
    end
    for (int n = 0; n < d_wait; n++) begin
      if (n == bad_at) begin
        tl.d_valid = 1'b1; tl.d_source = SRC + 8'd1; tl.d_data = ~ddata;
      end else begin
        tl.d_valid = 1'b0;
      end
      tick();
      tl.d_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL %s early rsp_valid at wait %0d got %b exp 0", tag, n, rsp_valid);
      end
    end
    tl.d_valid = 1'b1; tl.d_source = SRC; tl.d_data = ddata; tl.d_denied = denied;
    tl.d_size = 3'($urandom);
    tick();
    tl.d_valid = 1'b0; tl.d_denied = 1'b0; tl.d_data = {$urandom, $urandom};
    checks++;
    if ({rsp_valid, rsp_err, rsp_denied, tl.d_ready, rsp_data} !== {1'b1, 1'b0, denied, 1'b0, exp_data}) begin
      errors++; $display("FAIL %s response got v%b e%b dn%b dr%b %h exp v1 e0 dn%b dr0 %h", tag,
                         rsp_valid, rsp_err, rsp_denied, tl.d_ready, rsp_data, denied, exp_data);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({req_ready, tl.a_valid, tl.d_ready, rsp_valid, rsp_err, rsp_denied} !== 6'b100000 ||
        rsp_data !== 64'd0 || dut_payload() !== 154'd0) begin
      errors++; $display("FAIL reset_state got %b %h %h exp 100000 0 0",
                         {req_ready, tl.a_valid, tl.d_ready, rsp_valid, rsp_err, rsp_denied},
                         rsp_data, dut_payload());
    end
  endtask

  task automatic test_directed();
    do_txn("load_s32", 3'd0, 3'd0, 2'd2, 1'b1, 64'h1004, 64'h0, 64'h0000_0000_8000_0001, 0, 0, -1, 1'b0);
    tick();
    do_txn("store_b", 3'd1, 3'd5, 2'd0, 1'b0, 64'h2003, 64'hAB, 64'hDEAD_BEEF_CAFE_F00D, 4, 1, -1, 1'b0);
    tick();
    do_txn("arith_add", 3'd2, TL_PARAM_ADD, 2'd3, 1'b0, 64'h3000, 64'd5, 64'd10, 1, 2, -1, 1'b0);
    tick();
    do_txn("logic_denied", 3'd3, 3'd1, 2'd1, 1'b1, 64'h40, 64'h0F0F, 64'h0000_8001, 0, 0, -1, 1'b1);
    tick();
    do_txn("store_full", 3'd1, 3'd0, 2'd3, 1'b0, 64'h48, 64'h1122_3344_5566_7788, 64'hFFFF, 0, 0, -1, 1'b0);
    tick();
    do_txn("reserved_op", 3'd6, 3'd7, 2'd0, 1'b1, 64'h50, 64'h0, 64'h80, 0, 0, -1, 1'b0);
    tick();
  endtask

  task automatic test_bad_source();
    do_txn("bad_source", 3'd0, 3'd0, 2'd3, 1'b0, 64'h6000, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 3, 0, 1'b0);
    tick();
  endtask

  task automatic test_beat_wins_timeout();
    do_txn("beat_vs_timeout", 3'd0, 3'd0, 2'd0, 1'b1, 64'h7000, 64'h0, 64'h7F, 0, TO - 1, -1, 1'b0);
    tick();
  endtask

  task automatic test_timeout();
    int found;
    req_valid = 1'b1; req_op = 3'd0; req_size = 2'd3; req_signed = 1'b0; req_addr = 64'h8000;
    tick();
    req_valid = 1'b0;
    tl.a_ready = 1'b1;
    tick();
    tl.a_ready = 1'b0;
    found = -1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (rsp_valid === 1'b1) begin
        found = n;
        break;
      end
    end
    checks++;
    if (found != int'(TO) || rsp_err !== 1'b1 || rsp_data !== 64'd0) begin
      errors++; $display("FAIL timeout got cycle %0d err %b data %h exp cycle %0d err 1 data 0",
                         found, rsp_err, rsp_data, TO);
    end
    do_txn("after_timeout", 3'd0, 3'd0, 2'd0, 1'b0, 64'h8008, 64'h0, 64'hF0, 0, 0, -1, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    req_valid = 1'b1; req_op = 3'd0; req_size = 2'd1; req_addr = 64'h9000;
    tick();
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tl.a_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL reset_mid a_valid/req_ready got %b exp 01", {tl.a_valid, req_ready});
    end
    tick();
    #2 rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 4; n++) begin
      tl.a_ready = 1'b1; tl.d_valid = 1'b1; tl.d_source = SRC;
      tick();
      if (rsp_valid === 1'b1) seen++;
    end
    tl.a_ready = 1'b0; tl.d_valid = 1'b0;
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_mid stray rsp_valid got %0d exp 0", seen);
    end
    do_txn("load_u16", 3'd0, 3'd0, 2'd1, 1'b0, 64'h9002, 64'h0, 64'h1234_5678_9ABC_FFFF, 0, 0, -1, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++) begin
      logic [2:0] op;
      int d_wait;
      op = 3'($urandom);
      d_wait = int'($urandom_range(0, 5));
      do_txn($sformatf("rand%0d", i), op, 3'($urandom), 2'($urandom), 1'($urandom),
             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom_range(0, 3)), d_wait,
             (d_wait > 0) ? int'($urandom_range(0, d_wait - 1)) : -1, 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 2)) tick();
      end
    end
  endtask

  initial begin
    tl.a_ready = 1'b0; tl.d_valid = 1'b0; tl.d_opcode = 3'd1; tl.d_param = 2'd0;
    tl.d_size = 3'd0; tl.d_source = '0; tl.d_denied = 1'b0; tl.d_data = '0; tl.d_corrupt = 1'b0;
    #12;
    test_reset();
    #2 rst_n = 1'b1;
    tick();
    test_directed();
    test_bad_source();
    test_beat_wins_timeout();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule
